// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge. One transfer in flight; reads and
// writes are serialised with round-robin arbitration when both are pending.
// APB PSLVERR and ACCESS-phase timeouts are reported as AXI SLVERR.
module axil_apb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // AXI-Lite write address
  input  logic [ADDR_WIDTH-1:0]     aw_addr_i,
  input  logic [2:0]                aw_prot_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  // AXI-Lite write data
  input  logic [DATA_WIDTH-1:0]     w_data_i,
  input  logic [DATA_WIDTH/8-1:0]   w_strb_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  // AXI-Lite write response
  output logic [1:0]                b_resp_o,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  // AXI-Lite read address
  input  logic [ADDR_WIDTH-1:0]     ar_addr_i,
  input  logic [2:0]                ar_prot_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  // AXI-Lite read data
  output logic [DATA_WIDTH-1:0]     r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  // APB4 request
  output logic [ADDR_WIDTH-1:0]     paddr_o,
  output logic [2:0]                pprot_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  // APB4 completion
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StAccess = 3'd2;
  localparam logic [2:0] StWresp  = 3'd3;
  localparam logic [2:0] StRresp  = 3'd4;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  localparam bit          TimeoutEn    = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [2:0]  state_q;
  logic        last_wr_q;
  logic [15:0] wait_cnt_q;

  logic wr_cand;
  logic rd_cand;
  logic wr_grant;
  logic rd_grant;
  logic timed_out;

  // Arbitration: a lone candidate wins; on conflict, the opposite of the last grant wins.
  always_comb begin
    wr_cand  = aw_valid_i && w_valid_i;
    rd_cand  = ar_valid_i;
    wr_grant = wr_cand && (!rd_cand || !last_wr_q);
    rd_grant = rd_cand && (!wr_cand || last_wr_q);
  end

  // Ready outputs are combinational and only offered while idle.
  always_comb begin
    aw_ready_o = (state_q == StIdle) && wr_grant;
    w_ready_o  = (state_q == StIdle) && wr_grant;
    ar_ready_o = (state_q == StIdle) && rd_grant;
  end

  // Timeout fires on the last permitted ACCESS cycle when the slave is still stalling.
  always_comb begin
    timed_out = TimeoutEn && !pready_i && (wait_cnt_q == TimeoutLimit);
  end

  // Transfer FSM with registered APB request and AXI response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      last_wr_q  <= 1'b0;
      wait_cnt_q <= '0;
      paddr_o    <= '0;
      pprot_o    <= '0;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      pwdata_o   <= '0;
      pstrb_o    <= '0;
      b_resp_o   <= '0;
      b_valid_o  <= 1'b0;
      r_data_o   <= '0;
      r_resp_o   <= '0;
      r_valid_o  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_grant) begin
            paddr_o   <= aw_addr_i;
            pprot_o   <= aw_prot_i;
            pwrite_o  <= 1'b1;
            pwdata_o  <= w_data_i;
            pstrb_o   <= w_strb_i;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            last_wr_q <= 1'b1;
            state_q   <= StSetup;
          end else if (rd_grant) begin
            paddr_o   <= ar_addr_i;
            pprot_o   <= ar_prot_i;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            pstrb_o   <= '0;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            last_wr_q <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          penable_o  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StAccess;
        end
        StAccess: begin
          if (pready_i || timed_out) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            if (pwrite_o) begin
              b_valid_o <= 1'b1;
              b_resp_o  <= (timed_out || pslverr_i) ? RespSlverr : RespOkay;
              state_q   <= StWresp;
            end else begin
              r_valid_o <= 1'b1;
              r_resp_o  <= (timed_out || pslverr_i) ? RespSlverr : RespOkay;
              r_data_o  <= timed_out ? '0 : prdata_i;
              state_q   <= StRresp;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StWresp: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StRresp: begin
          if (r_ready_i) begin
            r_valid_o <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
